// File: rtl/bus_sram_target_pkg.sv
// Shared definitions for bus targets that front an asynchronous SRAM.
// Holds the default SRAM phase timing and the bus command bundle so other
// targets on the same request/ready bus can reuse them.
package bus_sram_target_pkg;

  // Extra wait cycles per SRAM phase on the reference board.
  localparam int SRAM_WAIT_CYCLES_DEFAULT = 1;
  // Largest supported WAIT_CYCLES value; sizes the phase counter.
  localparam int SRAM_WAIT_CYCLES_MAX     = 15;
  localparam int SRAM_WAIT_CNT_WIDTH      = $clog2(SRAM_WAIT_CYCLES_MAX + 1);

  // One bus command as presented by an initiator.
  typedef struct packed {
    logic        request;
    logic        rw;       // 1 = write, 0 = read
    logic [31:0] address;  // byte address
    logic [31:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/bus_sram_target.sv
// Purpose: bus target serving 32-bit words from a 16-bit async SRAM as two half-word phases.
// Latency: read 2*(WAIT_CYCLES+1)+1, write 2*(WAIT_CYCLES+2)+1 cycles from request to ready.
// Backpressure: initiator holds request until ready; ready is gated by request, one idle cycle between words.
module bus_sram_target
  import bus_sram_target_pkg::*;
#(
  parameter int ADDR_WIDTH  = 18,
  parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES_DEFAULT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_request,
  input  logic                  i_rw,
  input  logic [31:0]           i_address,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata,
  output logic                  o_ready,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [15:0]           o_sram_d,
  input  logic [15:0]           i_sram_d,
  output logic                  o_sram_d_oe,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_we_n
);

  typedef enum logic [2:0] {
    IDLE,
    READ_LO,
    READ_HI,
    WRITE_LO,
    HOLD_LO,
    WRITE_HI,
    HOLD_HI,
    DONE
  } state_t;

  localparam logic [SRAM_WAIT_CNT_WIDTH-1:0] WAIT_LOAD = SRAM_WAIT_CNT_WIDTH'(WAIT_CYCLES);

  bus_cmd_t bus_cmd;

  state_t                        state_q, state_d;
  logic [SRAM_WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]         sram_addr_q, sram_addr_d;
  logic [15:0]                   sram_d_q, sram_d_d;
  logic [15:0]                   wdata_hi_q, wdata_hi_d;
  logic [31:0]                   rdata_q, rdata_d;
  logic                          ce_n_q, ce_n_d;
  logic                          oe_n_q, oe_n_d;
  logic                          we_n_q, we_n_d;
  logic                          d_oe_q, d_oe_d;
  logic                          phase_end;

  // Byte-lane bits and address bits beyond the SRAM are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus_cmd.address[31:ADDR_WIDTH+1], bus_cmd.address[1:0]};

  assign bus_cmd   = '{request: i_request, rw: i_rw, address: i_address, wdata: i_wdata};
  assign phase_end = (cnt_q == '0);

  // Ready is a pure gate so it drops in the same cycle the initiator drops request.
  assign o_ready     = bus_cmd.request && (state_q == DONE);
  assign o_rdata     = rdata_q;
  assign o_sram_addr = sram_addr_q;
  assign o_sram_d    = sram_d_q;
  assign o_sram_d_oe = d_oe_q;
  assign o_sram_ce_n = ce_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_we_n = we_n_q;

  // State and all SRAM-facing outputs are registered; reset parks the SRAM deselected.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sram_addr_q <= '0;
      sram_d_q    <= '0;
      wdata_hi_q  <= '0;
      rdata_q     <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      d_oe_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sram_addr_q <= sram_addr_d;
      sram_d_q    <= sram_d_d;
      wdata_hi_q  <= wdata_hi_d;
      rdata_q     <= rdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      d_oe_q      <= d_oe_d;
    end
  end

  // Sequencing of the two half-word phases; every register holds unless a state moves it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sram_addr_d = sram_addr_q;
    sram_d_d    = sram_d_q;
    wdata_hi_d  = wdata_hi_q;
    rdata_d     = rdata_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    d_oe_d      = d_oe_q;

    case (state_q)
      IDLE: begin
        if (bus_cmd.request) begin
          // Command is captured here only; the low half always goes first.
          sram_addr_d = {bus_cmd.address[ADDR_WIDTH:2], 1'b0};
          wdata_hi_d  = bus_cmd.wdata[31:16];
          ce_n_d      = 1'b0;
          cnt_d       = WAIT_LOAD;
          if (bus_cmd.rw) begin
            d_oe_d   = 1'b1;
            sram_d_d = bus_cmd.wdata[15:0];
            we_n_d   = 1'b0;
            state_d  = WRITE_LO;
          end else begin
            oe_n_d  = 1'b0;
            state_d = READ_LO;
          end
        end
      end

      READ_LO: begin
        if (phase_end) begin
          rdata_d[15:0]  = i_sram_d;
          sram_addr_d[0] = 1'b1;
          cnt_d          = WAIT_LOAD;
          state_d        = READ_HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      READ_HI: begin
        if (phase_end) begin
          rdata_d[31:16] = i_sram_d;
          ce_n_d         = 1'b1;
          oe_n_d         = 1'b1;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      WRITE_LO: begin
        if (phase_end) begin
          // Release write enable while address and data stay put (hold time).
          we_n_d  = 1'b1;
          state_d = HOLD_LO;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      HOLD_LO: begin
        sram_addr_d[0] = 1'b1;
        sram_d_d       = wdata_hi_q;
        we_n_d         = 1'b0;
        cnt_d          = WAIT_LOAD;
        state_d        = WRITE_HI;
      end

      WRITE_HI: begin
        if (phase_end) begin
          we_n_d  = 1'b1;
          state_d = HOLD_HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      HOLD_HI: begin
        ce_n_d  = 1'b1;
        d_oe_d  = 1'b0;
        state_d = DONE;
      end

      DONE: begin
        // Leave only once the initiator has let go, guaranteeing an idle cycle.
        if (!bus_cmd.request) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_sram_target.sv
// Bench for bus_sram_target: two instances (WAIT_CYCLES 0 and 1), each on its own SRAM model.
// Instance index equals its WAIT_CYCLES. Expected data come from a word-level memory model.
// Expected latencies come from the phase-count formulas.
module tb_bus_sram_target;

  localparam int AW      = 18;
  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [1:0]           req, rw;
  logic [1:0][31:0]     addr, wdat, rdata;
  logic [1:0]           rdy;
  logic [1:0][AW-1:0]   s_addr;
  logic [1:0][15:0]     s_dout, s_din;
  logic [1:0]           s_doe, s_ce, s_oe, s_we;

  int n_tests = 0;
  int n_fail  = 0;

  // Word-level reference: key = instance * 2^20 + word index (byte address bits [AW:2]).
  logic [31:0] model [int];

  bus_sram_target #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut_w0 (
    .i_clock(clk), .i_reset(rst_n), .i_request(req[0]), .i_rw(rw[0]),
    .i_address(addr[0]), .i_wdata(wdat[0]), .o_rdata(rdata[0]), .o_ready(rdy[0]),
    .o_sram_addr(s_addr[0]), .o_sram_d(s_dout[0]), .i_sram_d(s_din[0]),
    .o_sram_d_oe(s_doe[0]), .o_sram_ce_n(s_ce[0]), .o_sram_oe_n(s_oe[0]),
    .o_sram_we_n(s_we[0])
  );

  bus_sram_target #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_dut_w1 (
    .i_clock(clk), .i_reset(rst_n), .i_request(req[1]), .i_rw(rw[1]),
    .i_address(addr[1]), .i_wdata(wdat[1]), .o_rdata(rdata[1]), .o_ready(rdy[1]),
    .o_sram_addr(s_addr[1]), .o_sram_d(s_dout[1]), .i_sram_d(s_din[1]),
    .o_sram_d_oe(s_doe[1]), .o_sram_ce_n(s_ce[1]), .o_sram_oe_n(s_oe[1]),
    .o_sram_we_n(s_we[1])
  );

  // Async SRAM model per instance plus a strobe-overlap monitor.
  for (genvar g = 0; g < 2; g++) begin : g_sram
    logic [15:0] mem [1<<AW];
    int viol = 0;
    always @(posedge clk)
      if (!s_ce[g] && !s_we[g] && s_doe[g]) mem[s_addr[g]] <= s_dout[g];
    assign s_din[g] = (!s_ce[g] && !s_oe[g]) ? mem[s_addr[g]] : 16'hA5A5;
    always @(negedge clk)
      if (rst_n) begin
        if (!s_oe[g] && !s_we[g]) viol++;
        if (s_doe[g] && !s_oe[g]) viol++;
      end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int mkey(input int idx, input logic [31:0] a);
    return idx * (1 << 20) + int'(a[AW:2]);
  endfunction

  // One full transaction; ends one edge after request drops, ready for the next raise.
  task automatic txn(input int idx, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input bit scramble, output logic [31:0] rd, output int lat);
    rw[idx] = wr; addr[idx] = a; wdat[idx] = wd; req[idx] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      if (scramble && lat == 1) begin
        #1;
        rw[idx] = 1'($urandom); addr[idx] = $urandom; wdat[idx] = $urandom;
      end
      @(negedge clk);
    end while (!rdy[idx] && lat < TIMEOUT);
    rd = rdata[idx];
    req[idx] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int idx, input logic [31:0] a, input logic [31:0] d, input bit scr);
    logic [31:0] rd;
    int lat;
    txn(idx, 1'b1, a, d, scr, rd, lat);
    check("wr_latency", 32'(lat), 32'(2 * (idx + 2) + 1));
    model[mkey(idx, a)] = d;
  endtask

  task automatic do_read(input int idx, input logic [31:0] a, input bit scr);
    logic [31:0] rd;
    int lat;
    txn(idx, 1'b0, a, 32'h0, scr, rd, lat);
    check("rd_latency", 32'(lat), 32'(2 * (idx + 1) + 1));
    if (model.exists(mkey(idx, a))) check("rd_data", rd, model[mkey(idx, a)]);
  endtask

  initial begin
    logic [31:0] a, d;
    int lat;

    rst_n = 1'b0;
    req = '0; rw = '0; addr = '0; wdat = '0;

    // Reset state on both instances.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_strobes", {28'h0, s_ce[i], s_oe[i], s_we[i], s_doe[i]}, 32'hE);
      check("rst_rdata", rdata[i], 32'h0);
      check("rst_addr", 32'(s_addr[i]), 32'h0);
      check("rst_sram_d", {16'h0, s_dout[i]}, 32'h0);
      check("rst_ready", 32'(rdy[i]), 32'h0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Write/read DEADBEEF at byte 0x10 on the WAIT_CYCLES=1 instance.
    do_write(1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    check("half8", {16'h0, g_sram[1].mem[8]}, 32'h0000_BEEF);
    check("half9", {16'h0, g_sram[1].mem[9]}, 32'h0000_DEAD);
    do_read(1, 32'h0000_0010, 1'b0);

    // Ready gating: hold 3 cycles, drop 1, re-raise a read.
    d = $urandom;
    rw[1] = 1'b1; addr[1] = 32'h20; wdat[1] = d; req[1] = 1'b1;
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!rdy[1] && lat < TIMEOUT);
    check("gate_wr_latency", 32'(lat), 32'd7);
    model[mkey(1, 32'h20)] = d;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("gate_hold", 32'(rdy[1]), 32'h1);
    end
    @(posedge clk); #1 req[1] = 1'b0;
    @(negedge clk);
    check("gate_dropped", 32'(rdy[1]), 32'h0);
    @(posedge clk); #1 rw[1] = 1'b0; req[1] = 1'b1;
    @(negedge clk);
    check("gate_reraise", 32'(rdy[1]), 32'h0);
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!rdy[1] && lat < TIMEOUT);
    check("gate_rd_latency", 32'(lat), 32'd5);
    check("gate_rd_data", rdata[1], d);
    req[1] = 1'b0;
    @(posedge clk); #1;

    // WAIT_CYCLES=0 burst of 16 words.
    for (int i = 0; i < 16; i++) do_write(0, 32'(i * 4), 32'(i) * 32'h0101_0101, 1'b0);
    for (int i = 0; i < 16; i++) do_read(0, 32'(i * 4), 1'b0);

    // Randomized traffic with junk upper bits and mid-transaction input changes.
    for (int n = 0; n < 40; n++) begin
      a = {12'($urandom), 1'b0, 13'h0, 4'($urandom), 2'($urandom)};
      if (($urandom % 2 == 0) || !model.exists(mkey(1, a)))
        do_write(1, a, $urandom, 1'($urandom));
      else
        do_read(1, a, 1'($urandom));
    end

    // Reset while in the high-half write phase.
    rw[1] = 1'b1; addr[1] = 32'h50; wdat[1] = $urandom; req[1] = 1'b1;
    repeat (1 + 3) @(posedge clk);
    #1;
    check("in_write_hi", {30'h0, s_we[1], s_addr[1][0]}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_strobes", {28'h0, s_ce[1], s_oe[1], s_we[1], s_doe[1]}, 32'hE);
    check("midrst_ready", 32'(rdy[1]), 32'h0);
    check("midrst_rdata", rdata[1], 32'h0);
    @(posedge clk); #1 rst_n = 1'b1; req[1] = 1'b0;
    model.delete(mkey(1, 32'h50));
    do_read(1, 32'h0000_0010, 1'b0);

    // Abort: drop request once the low read phase has started.
    rw[1] = 1'b0; addr[1] = 32'h20; req[1] = 1'b1;
    @(posedge clk); #1 req[1] = 1'b0;
    for (int k = 1; k <= 2 * 1 + 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_no_ready", 32'(rdy[1]), 32'h0);
    end
    check("abort_ce_off", 32'(s_ce[1]), 32'h1);
    do_read(1, 32'h20, 1'b0);
    do_write(1, 32'h24, $urandom, 1'b0);
    do_read(1, 32'h24, 1'b0);

    // Address aliasing: bit AW+2 set maps onto half-addresses 0/1.
    d = $urandom;
    do_write(1, 32'h0010_0000, d, 1'b0);
    check("wrap_half0", {16'h0, g_sram[1].mem[0]}, {16'h0, d[15:0]});
    check("wrap_half1", {16'h0, g_sram[1].mem[1]}, {16'h0, d[31:16]});
    do_read(1, 32'h0000_0000, 1'b0);
    do_read(1, 32'h0200_0000, 1'b0);

    check("proto_w0", 32'(g_sram[0].viol), 32'h0);
    check("proto_w1", 32'(g_sram[1].viol), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
